// File: rtl/controlador_medicion_periodo.sv
// Period measurement controller: synchronises a square wave, counts microseconds between
// rising edges, averages 2^N_PROM_LOG2 periods and reports through a valid/ack handshake.
module controlador_medicion_periodo #(
    parameter int DIV_US      = 50,
    parameter int ANCHO       = 12,
    parameter int N_PROM_LOG2 = 2,
    parameter int TIMEOUT_US  = 4000
) (
    input  logic             reloj_placa,
    input  logic             reset,
    input  logic             onda_cuad,
    input  logic             iniciar,
    input  logic             ack,
    output logic [ANCHO-1:0] valor_periodo,
    output logic             dato_listo,
    output logic             error_timeout,
    output logic             ocupado,
    output logic [1:0]       estado
);

    localparam int PW = $clog2(DIV_US);
    localparam int AW = ANCHO + N_PROM_LOG2;

    typedef logic [PW-1:0]        presc_t;
    typedef logic [ANCHO-1:0]     cnt_t;
    typedef logic [AW-1:0]        acum_t;
    typedef logic [N_PROM_LOG2:0] per_t;

    localparam presc_t PRESC_MAX  = presc_t'(DIV_US - 1);
    localparam cnt_t   TIMEOUT_CNT = cnt_t'(TIMEOUT_US);
    localparam per_t   N_PERIODOS  = per_t'(2 ** N_PROM_LOG2);

    typedef enum logic [1:0] {
        REPOSO        = 2'b00,
        ESPERA_FLANCO = 2'b01,
        MIDIENDO      = 2'b10,
        LISTO         = 2'b11
    } estado_t;

    estado_t est;
    logic    sinc_p0, sinc_p1, prev_p2;
    logic    flanco, activo, tick;
    presc_t  presc;
    cnt_t    cant_us;
    acum_t   acumulador, acum_nuevo;
    per_t    periodos, periodos_nuevo;

    function automatic cnt_t promedio(input acum_t suma);
        acum_t desplazado;
        desplazado = suma >> N_PROM_LOG2;
        return desplazado[ANCHO-1:0];
    endfunction

    // Stage p0/p1: two-flop synchroniser; stage p2: previous value for edge detect
    always_ff @(posedge reloj_placa or posedge reset) begin
        if (reset) begin
            sinc_p0 <= 1'b0;
            sinc_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sinc_p0 <= onda_cuad;
            sinc_p1 <= sinc_p0;
            prev_p2 <= sinc_p1;
        end
    end

    assign flanco = sinc_p1 & ~prev_p2;
    assign activo = (est == ESPERA_FLANCO) || (est == MIDIENDO);
    assign tick   = activo && (presc == PRESC_MAX);

    // Prescaler restarts on each edge so every period starts on a tick boundary
    always_ff @(posedge reloj_placa or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (!activo || flanco || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A tick landing on the edge cycle is still part of the period being closed
    always_comb begin
        acum_nuevo     = acumulador + acum_t'(cant_us) + acum_t'(tick);
        periodos_nuevo = periodos + 1'b1;
    end

    always_ff @(posedge reloj_placa or posedge reset) begin
        if (reset) begin
            est           <= REPOSO;
            valor_periodo <= '0;
            dato_listo    <= 1'b0;
            error_timeout <= 1'b0;
            ocupado       <= 1'b0;
            cant_us       <= '0;
            acumulador    <= '0;
            periodos      <= '0;
        end else begin
            case (est)
                REPOSO: begin
                    if (iniciar) begin
                        est           <= ESPERA_FLANCO;
                        ocupado       <= 1'b1;
                        error_timeout <= 1'b0;
                        cant_us       <= '0;
                        acumulador    <= '0;
                        periodos      <= '0;
                    end
                end
                ESPERA_FLANCO: begin
                    if (flanco) begin
                        est     <= MIDIENDO;
                        cant_us <= '0;
                    end else if (cant_us == TIMEOUT_CNT) begin
                        est           <= LISTO;
                        ocupado       <= 1'b0;
                        valor_periodo <= '1;
                        error_timeout <= 1'b1;
                        dato_listo    <= 1'b1;
                    end else if (tick) begin
                        cant_us <= cant_us + 1'b1;
                    end
                end
                MIDIENDO: begin
                    if (flanco) begin
                        acumulador <= acum_nuevo;
                        periodos   <= periodos_nuevo;
                        cant_us    <= '0;
                        if (periodos_nuevo == N_PERIODOS) begin
                            est           <= LISTO;
                            ocupado       <= 1'b0;
                            valor_periodo <= promedio(acum_nuevo);
                            dato_listo    <= 1'b1;
                        end
                    end else if (cant_us == TIMEOUT_CNT) begin
                        est           <= LISTO;
                        ocupado       <= 1'b0;
                        valor_periodo <= '1;
                        error_timeout <= 1'b1;
                        dato_listo    <= 1'b1;
                    end else if (tick) begin
                        cant_us <= cant_us + 1'b1;
                    end
                end
                LISTO: begin
                    if (ack) begin
                        est        <= REPOSO;
                        dato_listo <= 1'b0;
                    end
                end
                default: est <= REPOSO;
            endcase
        end
    end

    assign estado = est;

endmodule

// File: doc/controlador_medicion_periodo.md
Name: controlador_medicion_periodo

Overview:
Sequences one square-wave period measurement per request. It synchronises the raw input, detects rising edges and gates a prescaled microsecond timebase. It averages 2^N_PROM_LOG2 consecutive periods and hands the result to the display/UART side through a valid/ack handshake. It also flags a timeout when the input is stuck or too slow.

Parameters:
DIV_US, 50, board clocks per microsecond tick (50 MHz board clock); must be >= 2.
ANCHO, 12, width of the period result and of the per-period counter.
N_PROM_LOG2, 2, log2 of the number of periods averaged (default 4 periods).
TIMEOUT_US, 4000, microseconds without a rising edge before the block aborts; must be <= 2^ANCHO-1.

Ports:
reloj_placa  in  1  board clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
onda_cuad  in  1  raw, asynchronous square wave.
iniciar  in  1  one-cycle start request; honoured only in REPOSO.
ack  in  1  consumer acknowledge; honoured only in LISTO.
valor_periodo  out  ANCHO  averaged period in microseconds.
dato_listo  out  1  result valid.
error_timeout  out  1  the result is a timeout, not a measurement.
ocupado  out  1  high in ESPERA_FLANCO and MIDIENDO.
estado  out  2  current FSM state code.

Behaviour:
- Reset (async, any state, mid-measurement included):
  - estado=REPOSO; valor_periodo=0; dato_listo=0; error_timeout=0; ocupado=0.
  - Synchroniser flops, prescaler, cant_us, acumulador and periodos all cleared.
- Synchroniser and edge detect:
  - 2-flop synchroniser on onda_cuad, followed by a registered previous-value flop.
  - flanco = sync & ~prev.
  - Raw rising edge to internal flanco: 3 cycles.
- Prescaler:
  - Runs only in ESPERA_FLANCO and MIDIENDO; otherwise held at 0.
  - Loaded with 0 on every flanco cycle; otherwise increments.
  - When prescaler == DIV_US-1: tick=1 and prescaler wraps to 0.
- cant_us: +1 per tick; cleared on flanco and on entry to ESPERA_FLANCO.
- acumulador is ANCHO+N_PROM_LOG2 bits wide, so it never overflows.
- FSM states: REPOSO=00, ESPERA_FLANCO=01, MIDIENDO=10, LISTO=11.
  - REPOSO, iniciar=1: go to ESPERA_FLANCO; clear cant_us, acumulador, periodos, error_timeout.
  - ESPERA_FLANCO, flanco=1: go to MIDIENDO with cant_us=0.
  - ESPERA_FLANCO, cant_us reaches TIMEOUT_US: go to LISTO.
  - MIDIENDO, on flanco:
    - acumulador += cant_us + tick (a tick in the edge cycle belongs to the closing period).
    - periodos += 1; cant_us = 0.
  - MIDIENDO, periodos reaches 2^N_PROM_LOG2 (same edge cycle): go to LISTO.
    - valor_periodo = new acumulador >> N_PROM_LOG2 (truncating).
    - dato_listo=1.
  - MIDIENDO, cant_us reaches TIMEOUT_US before the next flanco: go to LISTO.
  - Any timeout: valor_periodo = all ones, error_timeout=1, dato_listo=1.
  - LISTO: outputs held stable until ack=1.
    - On ack: go to REPOSO; dato_listo=0 on the following cycle.
    - valor_periodo and error_timeout keep their last values until the next iniciar.
- Ignored inputs:
  - iniciar outside REPOSO is ignored.
  - ack outside LISTO is ignored.
  - ack and iniciar together in LISTO: REPOSO only, no restart.
- Timeout vs. edge: if timeout and flanco occur in the same cycle, flanco wins.
- Latency: dato_listo rises one clock after the internal flanco that closes the last period.

Test Plan:
1. Reset asserted mid-MIDIENDO (after 2 periods), then released → all outputs 0, estado=00, and the next iniciar starts from periodos=0.
2. DIV_US=4, N_PROM_LOG2=2, steady 40-clock period, iniciar pulse → 10 ticks per period; valor_periodo=10, dato_listo=1, error_timeout=0; held 20 cycles without ack, then cleared one cycle after ack.
3. Same setup, periods of 36/40/44/40 clocks → per-period counts 9/10/11/10, acumulador=40, valor_periodo=10.
4. TIMEOUT_US=100, onda_cuad held low after iniciar → about 400 clocks later estado=11, error_timeout=1, valor_periodo=0xFFF.
5. Four edges issued, then the wave stops in MIDIENDO → timeout 100 us after the last edge; valor=0xFFF and the partial acumulador is discarded.
6. iniciar pulsed during MIDIENDO and LISTO, ack pulsed in REPOSO, and ack+iniciar together in LISTO → no state effect except LISTO→REPOSO; a fresh iniciar is then required.
